// File: rtl/snek_board_sched.sv
`default_nettype none
// ============================================================================
// Module      : snek_board_sched
// Description : Single-port board RAM scheduler. The VGA tile renderer owns
//               the RAM on every cycle it asks for it; the snek game logic
//               is only admitted inside a per-step update window that opens
//               during vblank once every FRAME_DIV frames.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clk_i, rst_ni                 pixel clock, async active-low reset
//   vblank_i                      vertical blanking (clk-synchronous)
//   vid_req_i/vid_addr_i          renderer read request / address
//   vid_rdata_o/vid_rvalid_o      renderer read return (request + 2 cycles)
//   step_start_o                  1-cycle pulse when an update window opens
//   gm_valid_i/gm_ready_o         game request handshake
//   gm_we_i/gm_addr_i/gm_wdata_i  game command
//   gm_done_i                     game finished this step (closes window)
//   gm_rdata_o/gm_rvalid_o        game read return (accept + 2 cycles)
//   overrun_o                     sticky: vblank ended with window open
//   mem_addr_o/mem_we_o/mem_wdata_o  registered RAM command
//   mem_rdata_i                   sync RAM read data (1 cycle after address)
// ============================================================================
module snek_board_sched #(
    parameter int ADDR_W    = 10,
    parameter int DATA_W    = 2,
    parameter int FRAME_DIV = 8
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              vblank_i,
    input  logic              vid_req_i,
    input  logic [ADDR_W-1:0] vid_addr_i,
    output logic [DATA_W-1:0] vid_rdata_o,
    output logic              vid_rvalid_o,
    output logic              step_start_o,
    input  logic              gm_valid_i,
    output logic              gm_ready_o,
    input  logic              gm_we_i,
    input  logic [ADDR_W-1:0] gm_addr_i,
    input  logic [DATA_W-1:0] gm_wdata_i,
    input  logic              gm_done_i,
    output logic [DATA_W-1:0] gm_rdata_o,
    output logic              gm_rvalid_o,
    output logic              overrun_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic              mem_we_o,
    output logic [DATA_W-1:0] mem_wdata_o,
    input  logic [DATA_W-1:0] mem_rdata_i
);

    typedef enum logic [1:0] {
        ST_CLOSED = 2'd0,
        ST_OPEN   = 2'd1,
        ST_DONE   = 2'd2
    } state_e;

    localparam logic [7:0] FCNT_LAST = 8'(FRAME_DIV - 1);

    state_e            state_q, state_d;
    logic [7:0]        fcnt_q, fcnt_d;
    logic              vblank_q;
    logic              step_start_q, step_start_d;
    logic              overrun_q, overrun_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic              mem_we_q, mem_we_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
    // Return tags: stage 1 covers the RAM access cycle, stage 2 the data cycle
    logic              vtag1_q, gtag1_q, vtag2_q, gtag2_q;

    logic vb_rise;
    logic vb_fall;
    logic win_open;
    logic gm_ready;
    logic gm_xfer;

    assign vb_rise  = vblank_i & ~vblank_q;
    assign vb_fall  = ~vblank_i & vblank_q;
    assign win_open = vb_rise && (fcnt_q == FCNT_LAST);

    // Renderer always wins; gm_done blocks acceptance in the cycle it closes
    // the window so no transfer slips in after the game declared completion.
    assign gm_ready = (state_q == ST_OPEN) & ~vid_req_i & ~gm_done_i;
    assign gm_xfer  = gm_valid_i & gm_ready;

    // ------------------------------------------------------------------
    // Window FSM and frame divider
    // ------------------------------------------------------------------
    always_comb begin
        state_d      = state_q;
        fcnt_d       = fcnt_q;
        step_start_d = 1'b0;
        overrun_d    = overrun_q;

        if (vb_rise) begin
            fcnt_d = win_open ? 8'd0 : fcnt_q + 8'd1;
        end

        if (win_open) begin
            state_d      = ST_OPEN;
            step_start_d = 1'b1;
        end else begin
            case (state_q)
                ST_OPEN: begin
                    // A gm_done coinciding with the vblank fall means the game
                    // did finish in time, so it is not counted as an overrun.
                    if (vb_fall) begin
                        state_d = ST_CLOSED;
                        if (!gm_done_i) begin
                            overrun_d = 1'b1;
                        end
                    end else if (gm_done_i) begin
                        state_d = ST_DONE;
                    end
                end
                ST_DONE: begin
                    if (vb_fall) begin
                        state_d = ST_CLOSED;
                    end
                end
                default: begin
                    state_d = ST_CLOSED;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Command issue: idle cycles hold address/data, only the strobe drops
    // ------------------------------------------------------------------
    always_comb begin
        mem_addr_d  = mem_addr_q;
        mem_we_d    = 1'b0;
        mem_wdata_d = mem_wdata_q;
        if (vid_req_i) begin
            mem_addr_d = vid_addr_i;
        end else if (gm_xfer) begin
            mem_addr_d  = gm_addr_i;
            mem_we_d    = gm_we_i;
            mem_wdata_d = gm_wdata_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q      <= ST_CLOSED;
            fcnt_q       <= 8'd0;
            vblank_q     <= 1'b0;
            step_start_q <= 1'b0;
            overrun_q    <= 1'b0;
            mem_addr_q   <= '0;
            mem_we_q     <= 1'b0;
            mem_wdata_q  <= '0;
            vtag1_q      <= 1'b0;
            gtag1_q      <= 1'b0;
            vtag2_q      <= 1'b0;
            gtag2_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            fcnt_q       <= fcnt_d;
            vblank_q     <= vblank_i;
            step_start_q <= step_start_d;
            overrun_q    <= overrun_d;
            mem_addr_q   <= mem_addr_d;
            mem_we_q     <= mem_we_d;
            mem_wdata_q  <= mem_wdata_d;
            vtag1_q      <= vid_req_i;
            gtag1_q      <= gm_xfer & ~gm_we_i;
            vtag2_q      <= vtag1_q;
            gtag2_q      <= gtag1_q;
        end
    end

    // The RAM output register already provides the data cycle, so read data
    // is steered straight to the owner; gating keeps idle outputs at zero.
    assign vid_rvalid_o = vtag2_q;
    assign vid_rdata_o  = vtag2_q ? mem_rdata_i : '0;
    assign gm_rvalid_o  = gtag2_q;
    assign gm_rdata_o   = gtag2_q ? mem_rdata_i : '0;
    assign gm_ready_o   = gm_ready;
    assign step_start_o = step_start_q;
    assign overrun_o    = overrun_q;
    assign mem_addr_o   = mem_addr_q;
    assign mem_we_o     = mem_we_q;
    assign mem_wdata_o  = mem_wdata_q;

endmodule
`default_nettype wire

// File: tb/tb_snek_board_sched.sv
`default_nettype none
// ============================================================================
// Module      : tb_snek_board_sched
// Description : Scoreboard bench for snek_board_sched (FRAME_DIV = 3) with a
//               behavioural sync RAM. Stimulus pushes expected read returns
//               (cycle + data); monitors pop them when rvalid is seen.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_snek_board_sched;

    localparam int ADDR_W    = 10;
    localparam int DATA_W    = 2;
    localparam int FRAME_DIV = 3;

    logic              clk = 1'b0;
    logic              rst_ni;
    logic              vblank, vid_req, gm_valid, gm_we, gm_done;
    logic [ADDR_W-1:0] vid_addr, gm_addr;
    logic [DATA_W-1:0] gm_wdata;
    logic [DATA_W-1:0] vid_rdata, gm_rdata, mem_wdata, mem_rdata;
    logic              vid_rvalid, step_start, gm_ready, gm_rvalid, overrun, mem_we;
    logic [ADDR_W-1:0] mem_addr;

    logic [DATA_W-1:0] ram [1024];
    int                cyc = 0;
    int                n_cmp = 0;
    int                n_err = 0;
    int                step_cnt = 0;

    typedef struct {
        int               cyc;
        logic [DATA_W-1:0] d;
    } exp_t;
    exp_t vq[$];
    exp_t gq[$];

    snek_board_sched #(
        .ADDR_W    (ADDR_W),
        .DATA_W    (DATA_W),
        .FRAME_DIV (FRAME_DIV)
    ) dut (
        .clk_i        (clk),
        .rst_ni       (rst_ni),
        .vblank_i     (vblank),
        .vid_req_i    (vid_req),
        .vid_addr_i   (vid_addr),
        .vid_rdata_o  (vid_rdata),
        .vid_rvalid_o (vid_rvalid),
        .step_start_o (step_start),
        .gm_valid_i   (gm_valid),
        .gm_ready_o   (gm_ready),
        .gm_we_i      (gm_we),
        .gm_addr_i    (gm_addr),
        .gm_wdata_i   (gm_wdata),
        .gm_done_i    (gm_done),
        .gm_rdata_o   (gm_rdata),
        .gm_rvalid_o  (gm_rvalid),
        .overrun_o    (overrun),
        .mem_addr_o   (mem_addr),
        .mem_we_o     (mem_we),
        .mem_wdata_o  (mem_wdata),
        .mem_rdata_i  (mem_rdata)
    );

    always #20 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Sync RAM model; contents preloaded on the first edge (inside reset)
    always @(posedge clk) begin
        if (cyc == 0) begin
            for (int i = 0; i < 1024; i++) ram[i] <= '0;
            ram[10'h005] <= 2'b10;
            ram[10'h006] <= 2'b01;
            ram[10'h007] <= 2'b11;
            ram[10'h010] <= 2'b01;
        end else if (mem_we) begin
            ram[mem_addr] <= mem_wdata;
        end
        mem_rdata <= ram[mem_addr];
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // ---------------- monitors ----------------
    always @(negedge clk) begin
        if (rst_ni) begin
            if (step_start) step_cnt++;
            if (vid_rvalid) begin
                if (vq.size() == 0) begin
                    chk("vid_unexpected_rvalid", vid_rvalid, 0);
                end else begin
                    exp_t e;
                    e = vq.pop_front();
                    chk("vid_rvalid_cycle", cyc, e.cyc);
                    chk("vid_rdata", vid_rdata, e.d);
                end
            end
            if (gm_rvalid) begin
                if (gq.size() == 0) begin
                    chk("gm_unexpected_rvalid", gm_rvalid, 0);
                end else begin
                    exp_t e;
                    e = gq.pop_front();
                    chk("gm_rvalid_cycle", cyc, e.cyc);
                    chk("gm_rdata", gm_rdata, e.d);
                end
            end
        end
    end

    task automatic check_all_zero(input string tag);
        chk({tag, "_vid_rdata"},  vid_rdata,  0);
        chk({tag, "_vid_rvalid"}, vid_rvalid, 0);
        chk({tag, "_step_start"}, step_start, 0);
        chk({tag, "_gm_ready"},   gm_ready,   0);
        chk({tag, "_gm_rdata"},   gm_rdata,   0);
        chk({tag, "_gm_rvalid"},  gm_rvalid,  0);
        chk({tag, "_overrun"},    overrun,    0);
        chk({tag, "_mem_addr"},   mem_addr,   0);
        chk({tag, "_mem_we"},     mem_we,     0);
        chk({tag, "_mem_wdata"},  mem_wdata,  0);
    endtask

    // Raise vblank in cycle c; step_start must appear in c+1 only if this
    // rise completes the frame divider. Returns in cycle c+1.
    task automatic vrise(input bit exp_open);
        vblank = 1'b1;
        @(negedge clk);
        chk("step_start_early", step_start, 0);
        tick;
        @(negedge clk);
        chk("step_start", step_start, exp_open);
        chk("gm_ready_window", gm_ready, exp_open && !vid_req && !gm_done);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: run did not finish, cycle %0d", cyc);
        $fatal(1);
    end

    int               va[3] = '{10'h005, 10'h006, 10'h007};
    logic [DATA_W-1:0] vd[3] = '{2'b10, 2'b01, 2'b11};

    initial begin
        rst_ni = 1'b0; vblank = 1'b0; vid_req = 1'b0; vid_addr = '0;
        gm_valid = 1'b0; gm_we = 1'b0; gm_addr = '0; gm_wdata = '0; gm_done = 1'b0;
        repeat (2) tick;
        @(negedge clk);
        check_all_zero("rst0");
        rst_ni = 1'b1;
        repeat (2) tick;

        // Reset one cycle after a renderer read issues: it must never return
        vid_req = 1'b1; vid_addr = 10'h005;
        tick;
        vid_req = 1'b0;
        rst_ni  = 1'b0;
        @(negedge clk);
        check_all_zero("rst1");
        tick;
        rst_ni = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk("no_rvalid_after_rst", vid_rvalid, 0);
            tick;
        end

        // Back-to-back renderer reads, data in N+2
        vid_req = 1'b1;
        for (int i = 0; i < 3; i++) begin
            vid_addr = ADDR_W'(va[i]);
            vq.push_back('{cyc + 2, vd[i]});
            tick;
        end
        vid_req = 1'b0;
        repeat (3) tick;

        // Game write pending while CLOSED: two non-opening frames
        gm_valid = 1'b1; gm_we = 1'b1; gm_addr = 10'h020; gm_wdata = 2'b11;
        for (int k = 0; k < 2; k++) begin
            vrise(1'b0);
            repeat (3) tick;
            vblank = 1'b0;
            repeat (4) begin
                @(negedge clk);
                chk("gm_ready_closed", gm_ready, 0);
                tick;
            end
        end

        // Third rise opens the window; the pending write is accepted at once
        vrise(1'b1);
        tick;
        gm_valid = 1'b0; gm_we = 1'b0;

        // Renderer and game collide in N: renderer wins
        vid_req = 1'b1; vid_addr = 10'h006;
        gm_valid = 1'b1; gm_addr = 10'h010;
        vq.push_back('{cyc + 2, 2'b01});
        @(negedge clk);
        chk("gm_ready_collide", gm_ready, 0);
        tick;
        vid_req = 1'b0;
        gq.push_back('{cyc + 2, 2'b01});
        @(negedge clk);
        chk("mem_addr_vid_won", mem_addr, 10'h006);
        chk("gm_ready_after_vid", gm_ready, 1);
        tick;

        // Read back the game write
        gm_addr = 10'h020;
        gq.push_back('{cyc + 2, 2'b11});
        @(negedge clk);
        chk("gm_ready_readback", gm_ready, 1);
        tick;

        // gm_done closes the window; nothing accepted that cycle or after
        gm_addr = 10'h030; gm_done = 1'b1;
        @(negedge clk);
        chk("gm_ready_done_cycle", gm_ready, 0);
        tick;
        gm_done = 1'b0;
        @(negedge clk);
        chk("gm_ready_done_state", gm_ready, 0);
        chk("ram_write_0x020", ram[10'h020], 2'b11);
        tick;
        gm_valid = 1'b0;
        vblank = 1'b0;
        repeat (3) tick;
        @(negedge clk);
        chk("overrun_after_done", overrun, 0);
        tick;

        // Frames 4 and 5 do not open
        for (int k = 0; k < 2; k++) begin
            vrise(1'b0);
            repeat (2) tick;
            vblank = 1'b0;
            repeat (3) tick;
        end

        // Frame 6 opens; no gm_done. Transfer in the last OPEN cycle.
        vrise(1'b1);
        repeat (2) tick;
        vblank = 1'b0;
        gm_valid = 1'b1; gm_we = 1'b0; gm_addr = 10'h010;
        gq.push_back('{cyc + 2, 2'b01});
        @(negedge clk);
        chk("gm_ready_last_open", gm_ready, 1);
        tick;
        @(negedge clk);
        chk("gm_ready_after_close", gm_ready, 0);
        chk("overrun_set", overrun, 1);
        tick;
        gm_valid = 1'b0;
        repeat (3) tick;

        // Overrun stays set through a later frame
        vrise(1'b0);
        repeat (2) tick;
        vblank = 1'b0;
        repeat (3) tick;
        @(negedge clk);
        chk("overrun_sticky", overrun, 1);
        repeat (4) tick;

        @(negedge clk);
        chk("vid_responses_outstanding", vq.size(), 0);
        chk("gm_responses_outstanding", gq.size(), 0);
        chk("step_start_pulses", step_cnt, 2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
